// File: rtl/gfg_pkg.sv
// Shared types for the rectangle rasterizer: geometry defaults, FSM states, {z, color} pixel packing.
// Pure declarations: no latency and no flow control live here.
package gfg_pkg;

    localparam int DEF_HORIZ_RES      = 640;
    localparam int DEF_VERT_RES       = 480;
    localparam int DEF_X_ADDR_W       = $clog2(DEF_HORIZ_RES);
    localparam int DEF_Y_ADDR_W       = $clog2(DEF_VERT_RES);

    localparam int PIX_COLOR_W        = 12;
    localparam int PIX_Z_W            = 2;
    localparam int FRAME_BUFFER_WIDTH = PIX_COLOR_W + PIX_Z_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_RECT,
        ST_SETUP,
        ST_RD,
        ST_WR
    } raster_state_t;

    // Colour occupies the low bits so a colour-only reader can ignore Z.
    function automatic logic [FRAME_BUFFER_WIDTH-1:0] pack_pixel(
        input logic [PIX_Z_W-1:0]     z,
        input logic [PIX_COLOR_W-1:0] color
    );
        return {z, color};
    endfunction

    function automatic logic [PIX_Z_W-1:0] pixel_z(input logic [FRAME_BUFFER_WIDTH-1:0] px);
        return px[FRAME_BUFFER_WIDTH-1 -: PIX_Z_W];
    endfunction

    function automatic logic [PIX_COLOR_W-1:0] pixel_color(input logic [FRAME_BUFFER_WIDTH-1:0] px);
        return px[PIX_COLOR_W-1:0];
    endfunction

endpackage

// File: rtl/gfg_xy_scan_counter.sv
// Loadable row-major x/y iterator over inclusive bounds; load puts it at (x_lo, y_lo) on the next edge.
// A step advances one pixel per cycle, wrapping at the bounds; o_last flags the final pixel.
module gfg_xy_scan_counter #(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic           i_clk,
    input  logic           i_arst,
    input  logic           i_load,
    input  logic [X_W-1:0] i_x_lo,
    input  logic [X_W-1:0] i_x_hi,
    input  logic [Y_W-1:0] i_y_lo,
    input  logic [Y_W-1:0] i_y_hi,
    input  logic           i_step,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last
);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] r_x_lo;
    logic [X_W-1:0] r_x_hi;
    logic [Y_W-1:0] r_y_lo;
    logic [Y_W-1:0] r_y_hi;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_x_lo <= '0;
            r_x_hi <= '0;
            r_y_lo <= '0;
            r_y_hi <= '0;
        end else if (i_load) begin
            r_x    <= i_x_lo;
            r_y    <= i_y_lo;
            r_x_lo <= i_x_lo;
            r_x_hi <= i_x_hi;
            r_y_lo <= i_y_lo;
            r_y_hi <= i_y_hi;
        end else if (i_step) begin
            if (r_x == r_x_hi) begin
                r_x <= r_x_lo;
                r_y <= (r_y == r_y_hi) ? r_y_lo : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == r_x_hi) && (r_y == r_y_hi);

endmodule

// File: rtl/gfg_rect_rasterizer.sv
// Fills the back frame buffer: clears it on each new frame, then draws Z-tested rectangles by read-modify-write.
// Clear is 1 pixel/cycle; a rectangle takes 1 + 2*w*h cycles; rectangle commands are valid/ready, held off while drawing.
module gfg_rect_rasterizer
    import gfg_pkg::*;
#(
    parameter int VERT_RESOLUTION  = DEF_VERT_RES,
    parameter int HORIZ_RESOLUTION = DEF_HORIZ_RES,
    parameter int COLOR_DEPTH      = PIX_COLOR_W,
    parameter int Z_DEPTH          = PIX_Z_W,
    parameter int CLEAR_COLOR      = 0
) (
    input  logic                                i_clk,
    input  logic                                i_arst,
    input  logic                                i_new_frame,
    input  logic                                i_rect_valid,
    output logic                                o_rect_ready,
    input  logic [$clog2(HORIZ_RESOLUTION)-1:0] i_rect_x0,
    input  logic [$clog2(HORIZ_RESOLUTION)-1:0] i_rect_x1,
    input  logic [$clog2(VERT_RESOLUTION)-1:0]  i_rect_y0,
    input  logic [$clog2(VERT_RESOLUTION)-1:0]  i_rect_y1,
    input  logic [COLOR_DEPTH-1:0]              i_rect_color,
    input  logic [Z_DEPTH-1:0]                  i_rect_z,
    input  logic                                i_frame_done,
    output logic                                o_raster_in_progress,
    output logic [$clog2(VERT_RESOLUTION)-1:0]  o_vert_write_addr,
    output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_horiz_write_addr,
    output logic                                o_write_en,
    output logic [COLOR_DEPTH+Z_DEPTH-1:0]      o_write_pixel_data,
    input  logic [COLOR_DEPTH+Z_DEPTH-1:0]      i_read_pixel_data
);

    localparam int X_W = $clog2(HORIZ_RESOLUTION);
    localparam int Y_W = $clog2(VERT_RESOLUTION);

    // Limits are one bit wider so a full power-of-two resolution is representable.
    localparam logic [X_W:0]   X_LIM = (X_W+1)'(HORIZ_RESOLUTION);
    localparam logic [Y_W:0]   Y_LIM = (Y_W+1)'(VERT_RESOLUTION);
    localparam logic [X_W-1:0] X_MAX = X_W'(HORIZ_RESOLUTION - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(VERT_RESOLUTION - 1);

    localparam logic [FRAME_BUFFER_WIDTH-1:0] CLEAR_PIXEL =
        pack_pixel({PIX_Z_W{1'b1}}, PIX_COLOR_W'(CLEAR_COLOR));

    raster_state_t r_state;
    raster_state_t w_state_nxt;

    logic [X_W-1:0]         r_x0;
    logic [X_W-1:0]         r_x1;
    logic [Y_W-1:0]         r_y0;
    logic [Y_W-1:0]         r_y1;
    logic [COLOR_DEPTH-1:0] r_color;
    logic [Z_DEPTH-1:0]     r_z;

    logic           w_accept;
    logic [X_W-1:0] w_x1_clip;
    logic [Y_W-1:0] w_y1_clip;
    logic           w_empty;
    logic           w_z_pass;

    logic           w_ld;
    logic [X_W-1:0] w_ld_x_lo;
    logic [X_W-1:0] w_ld_x_hi;
    logic [Y_W-1:0] w_ld_y_lo;
    logic [Y_W-1:0] w_ld_y_hi;
    logic           w_step;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic           w_last;

    gfg_xy_scan_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_load (w_ld),
        .i_x_lo (w_ld_x_lo),
        .i_x_hi (w_ld_x_hi),
        .i_y_lo (w_ld_y_lo),
        .i_y_hi (w_ld_y_hi),
        .i_step (w_step),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_last (w_last)
    );

    assign w_accept  = (r_state == ST_WAIT_RECT) && i_rect_valid;
    assign w_x1_clip = ({1'b0, r_x1} >= X_LIM) ? X_MAX : r_x1;
    assign w_y1_clip = ({1'b0, r_y1} >= Y_LIM) ? Y_MAX : r_y1;
    assign w_empty   = (r_x0 > w_x1_clip) || (r_y0 > w_y1_clip) ||
                       ({1'b0, r_x0} >= X_LIM) || ({1'b0, r_y0} >= Y_LIM);
    // Strictly nearer only: an equal depth leaves the existing pixel untouched.
    assign w_z_pass  = r_z < pixel_z(i_read_pixel_data);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_color <= '0;
            r_z     <= '0;
        end else if (w_accept) begin
            r_x0    <= i_rect_x0;
            r_x1    <= i_rect_x1;
            r_y0    <= i_rect_y0;
            r_y1    <= i_rect_y1;
            r_color <= i_rect_color;
            r_z     <= i_rect_z;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_ld               = 1'b0;
        w_ld_x_lo          = '0;
        w_ld_x_hi          = X_MAX;
        w_ld_y_lo          = '0;
        w_ld_y_hi          = Y_MAX;
        w_step             = 1'b0;
        o_rect_ready       = 1'b0;
        o_write_en         = 1'b0;
        o_write_pixel_data = '0;

        case (r_state)
            ST_IDLE: begin
                if (i_new_frame) begin
                    w_ld        = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_write_en         = 1'b1;
                o_write_pixel_data = CLEAR_PIXEL;
                if (w_last) begin
                    w_state_nxt = ST_WAIT_RECT;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_WAIT_RECT: begin
                o_rect_ready = 1'b1;
                if (i_rect_valid) begin
                    w_state_nxt = ST_SETUP;
                end else if (i_frame_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (w_empty) begin
                    w_state_nxt = ST_WAIT_RECT;
                end else begin
                    w_ld        = 1'b1;
                    w_ld_x_lo   = r_x0;
                    w_ld_x_hi   = w_x1_clip;
                    w_ld_y_lo   = r_y0;
                    w_ld_y_hi   = w_y1_clip;
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                w_state_nxt = ST_WR;
            end
            ST_WR: begin
                if (w_z_pass) begin
                    o_write_en         = 1'b1;
                    o_write_pixel_data = pack_pixel(r_z, r_color);
                end
                if (w_last) begin
                    w_state_nxt = ST_WAIT_RECT;
                end else begin
                    w_step      = 1'b1;
                    w_state_nxt = ST_RD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The scan counter only moves while writing or reading, so addresses hold otherwise.
    assign o_vert_write_addr    = w_y;
    assign o_horiz_write_addr   = w_x;
    assign o_raster_in_progress = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gfg_rect_rasterizer.sv
// Bench for gfg_rect_rasterizer on an 8x4 frame with a 1-cycle-latency frame buffer model.
// A depth-tested frame array predicts every write, its order and each command's latency.
module tb_gfg_rect_rasterizer;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int PW = 14;

    logic          clk;
    logic          arst;
    logic          new_frame;
    logic          rect_valid;
    logic          rect_ready;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic [11:0]   color;
    logic [1:0]    z;
    logic          frame_done;
    logic          in_prog;
    logic [YW-1:0] vaddr;
    logic [XW-1:0] haddr;
    logic          we;
    logic [PW-1:0] wdata;
    logic [PW-1:0] rdata;

    gfg_rect_rasterizer #(
        .VERT_RESOLUTION  (V),
        .HORIZ_RESOLUTION (H),
        .COLOR_DEPTH      (12),
        .Z_DEPTH          (2),
        .CLEAR_COLOR      (0)
    ) dut (
        .i_clk                (clk),
        .i_arst               (arst),
        .i_new_frame          (new_frame),
        .i_rect_valid         (rect_valid),
        .o_rect_ready         (rect_ready),
        .i_rect_x0            (x0),
        .i_rect_x1            (x1),
        .i_rect_y0            (y0),
        .i_rect_y1            (y1),
        .i_rect_color         (color),
        .i_rect_z             (z),
        .i_frame_done         (frame_done),
        .o_raster_in_progress (in_prog),
        .o_vert_write_addr    (vaddr),
        .o_horiz_write_addr   (haddr),
        .o_write_en           (we),
        .o_write_pixel_data   (wdata),
        .i_read_pixel_data    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [PW-1:0] mem [0:H*V-1];
    always @(posedge clk) begin
        rdata <= mem[{vaddr, haddr}];
        if (we) mem[{vaddr, haddr}] <= wdata;
    end

    // Every observed write as (row << 17) | (col << 14) | pixel.
    int wq[$];
    always @(negedge clk) begin
        if (we === 1'b1) wq.push_back(int'({vaddr, haddr, wdata}));
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int eq[$];
    int fb [0:H*V-1];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic compare_writes(input string tag, input int base);
        int n_bad = 0;
        check({tag, "_nwrites"}, wq.size() - base, eq.size());
        for (int i = 0; i < eq.size(); i++) begin
            if (base + i >= wq.size()) n_bad++;
            else if (wq[base + i] != eq[i]) n_bad++;
        end
        check({tag, "_wlist"}, n_bad, 0);
    endtask

    // Reference rectangle draw: clip, depth-test against the model frame, return expected latency.
    task automatic model_rect(input int ax0, input int ax1, input int ay0, input int ay1,
                              input int acol, input int az, output int cyc);
        int cx1 = (ax1 > H - 1) ? H - 1 : ax1;
        int cy1 = (ay1 > V - 1) ? V - 1 : ay1;
        eq.delete();
        if (ax0 > cx1 || ay0 > cy1 || ax0 >= H || ay0 >= V) begin
            cyc = 1;
        end else begin
            cyc = 1 + 2 * (cx1 - ax0 + 1) * (cy1 - ay0 + 1);
            for (int yy = ay0; yy <= cy1; yy++) begin
                for (int xx = ax0; xx <= cx1; xx++) begin
                    if (az < (fb[yy * H + xx] >> 12)) begin
                        fb[yy * H + xx] = az * 4096 + acol;
                        eq.push_back((yy << 17) | (xx << 14) | fb[yy * H + xx]);
                    end
                end
            end
        end
    endtask

    task automatic do_clear(input string tag, input int pulse_at);
        int base;
        int c = 0;
        eq.delete();
        for (int i = 0; i < H * V; i++) begin
            fb[i] = 32'h3000;
            eq.push_back(((i / H) << 17) | ((i % H) << 14) | 32'h3000);
        end
        @(negedge clk);
        check({tag, "_idle"}, int'(in_prog), 0);
        base = wq.size();
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        check({tag, "_rise"}, int'(in_prog), 1);
        while (rect_ready !== 1'b1 && c < 2000) begin
            new_frame = (c == pulse_at);
            @(negedge clk);
            c++;
        end
        new_frame = 1'b0;
        check({tag, "_lat"}, c, 32);
        compare_writes(tag, base);
    endtask

    task automatic do_rect(input string tag, input int ax0, input int ax1, input int ay0,
                           input int ay1, input int acol, input int az, input bit with_done);
        int base;
        int exp_cyc;
        int c = 0;
        model_rect(ax0, ax1, ay0, ay1, acol, az, exp_cyc);
        check({tag, "_rdy"}, int'(rect_ready), 1);
        base       = wq.size();
        x0         = XW'(ax0);
        x1         = XW'(ax1);
        y0         = YW'(ay0);
        y1         = YW'(ay1);
        color      = 12'(acol);
        z          = 2'(az);
        rect_valid = 1'b1;
        frame_done = with_done;
        @(negedge clk);
        rect_valid = 1'b0;
        frame_done = 1'b0;
        if (with_done) check({tag, "_still_busy"}, int'(in_prog), 1);
        while (rect_ready !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_lat"}, c, exp_cyc);
        compare_writes(tag, base);
    endtask

    task automatic check_fb(input string tag);
        int n_bad = 0;
        for (int i = 0; i < H * V; i++) begin
            if (int'(mem[i]) != fb[i]) n_bad++;
        end
        check(tag, n_bad, 0);
    endtask

    initial begin
        int base;
        int rx0, rx1, ry0, ry1;

        arst       = 1'b1;
        new_frame  = 1'b0;
        rect_valid = 1'b0;
        frame_done = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0; z = '0;
        repeat (3) @(negedge clk);
        check("rst_we",    int'(we), 0);
        check("rst_busy",  int'(in_prog), 0);
        check("rst_ready", int'(rect_ready), 0);
        check("rst_addr",  int'({vaddr, haddr}), 0);
        check("rst_data",  int'(wdata), 0);
        arst = 1'b0;
        @(negedge clk);
        check("idle_ready", int'(rect_ready), 0);

        // Frame 1, with a stray new_frame during the clear pass.
        do_clear("clr1", 5);
        do_rect("r_small", 1, 2, 1, 2, 12'hABC, 1, 1'b0);
        do_rect("r_full",  0, 3, 0, 3, 12'h123, 2, 1'b0);
        do_rect("r_tie",   0, 3, 0, 3, 12'h456, 2, 1'b0);
        do_rect("r_edge",  5, 7, 0, 0, 12'h777, 0, 1'b0);
        do_rect("r_empty", 5, 3, 0, 0, 12'h888, 0, 1'b0);
        do_rect("r_both",  6, 6, 3, 3, 12'h999, 1, 1'b1);
        check_fb("fb_directed");

        for (int k = 0; k < 14; k++) begin
            rx0 = $urandom_range(0, H - 1);
            rx1 = $urandom_range(0, H - 1);
            ry0 = $urandom_range(0, V - 1);
            ry1 = $urandom_range(0, V - 1);
            do_rect($sformatf("rnd%0d", k), rx0, rx1, ry0, ry1,
                    $urandom_range(0, 4095), $urandom_range(0, 3), 1'b0);
        end
        check_fb("fb_random");

        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        check("done_busy",  int'(in_prog), 0);
        check("done_ready", int'(rect_ready), 0);

        // Frame 2: abort a large rectangle with reset part-way through.
        do_clear("clr2", -1);
        x0 = 3'd0; x1 = 3'd7; y0 = 2'd0; y1 = 2'd3; color = 12'h5A5; z = 2'd0;
        rect_valid = 1'b1;
        @(negedge clk);
        rect_valid = 1'b0;
        repeat (6) @(negedge clk);
        arst = 1'b1;
        #1;
        check("abort_we",    int'(we), 0);
        check("abort_busy",  int'(in_prog), 0);
        check("abort_ready", int'(rect_ready), 0);
        check("abort_addr",  int'({vaddr, haddr}), 0);
        check("abort_data",  int'(wdata), 0);
        base = wq.size();
        repeat (3) @(negedge clk);
        arst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_abort_writes", wq.size() - base, 0);
        check("post_abort_busy", int'(in_prog), 0);

        do_clear("clr3", -1);
        do_rect("r_after", 2, 4, 1, 2, 12'h0F0, 2, 1'b0);
        check_fb("fb_final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
